// File: rtl/nanorv32_ascii_reg_parser.sv
// ASCII register-name parser: folds a character stream into tokens and decodes each
// token ("a0", "fp", "x17", ...) into a 5-bit RV32 register index with an error flag.
module nanorv32_ascii_reg_parser #(
    parameter int unsigned TOK_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [4:0] reg_idx,
    output logic       reg_err,
    output logic       reg_valid,
    input  logic       reg_ready
);

    // The decoder always inspects four characters, so the buffer never shrinks below that.
    localparam int unsigned BufLen = (TOK_LEN > 4) ? TOK_LEN : 4;
    localparam int unsigned LenW   = $clog2(TOK_LEN + 1);

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    state_e                  state_q, state_d;
    logic [BufLen-1:0][7:0]  tok_q, tok_d;
    logic [LenW-1:0]         len_q, len_d;
    logic                    ovf_q, ovf_d;
    logic [4:0]              idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;

    logic                    accept;
    logic                    is_delim;
    logic [7:0]              ch_fold;
    logic [4:0]              dec_idx;
    logic                    dec_err;

    assign char_ready = (state_q != StEmit) && !flush;
    assign accept     = char_valid && char_ready;
    assign is_delim   = char_in inside {8'h20, 8'h2C, 8'h09, 8'h0D, 8'h0A, 8'h00};
    assign ch_fold    = (char_in >= "A" && char_in <= "Z") ? char_in + 8'h20 : char_in;

    assign reg_idx    = idx_q;
    assign reg_err    = err_q;
    assign reg_valid  = valid_q;

    always_comb begin
        logic [7:0] c0, c1, c2, c3;
        logic [7:0] num;
        logic       hit;
        logic [4:0] val;
        int         n;
        c0  = tok_q[0];
        c1  = tok_q[1];
        c2  = tok_q[2];
        c3  = tok_q[3];
        n   = int'(len_q);
        num = 8'((c1 - 8'h30) * 8'd10 + (c2 - 8'h30));
        hit = 1'b0;
        val = 5'd0;
        if (n == 4) begin
            if ({c0, c1, c2, c3} == "zero") hit = 1'b1;
        end else if (n == 2) begin
            case (c0)
                "r": if (c1 == "a") begin hit = 1'b1; val = 5'd1; end
                "g": if (c1 == "p") begin hit = 1'b1; val = 5'd3; end
                "f": if (c1 == "p") begin hit = 1'b1; val = 5'd8; end
                "s": begin
                    if (c1 == "p") begin
                        hit = 1'b1; val = 5'd2;
                    end else if (c1 == "o") begin
                        hit = 1'b1; val = 5'd8;
                    end else if (c1 inside {["0":"1"]}) begin
                        hit = 1'b1; val = 5'(c1 - 8'h30) + 5'd8;
                    end else if (c1 inside {["2":"9"]}) begin
                        hit = 1'b1; val = 5'(c1 - 8'h32) + 5'd18;
                    end
                end
                "t": begin
                    if (c1 == "p") begin
                        hit = 1'b1; val = 5'd4;
                    end else if (c1 inside {["0":"2"]}) begin
                        hit = 1'b1; val = 5'(c1 - 8'h30) + 5'd5;
                    end else if (c1 inside {["3":"6"]}) begin
                        hit = 1'b1; val = 5'(c1 - 8'h33) + 5'd28;
                    end
                end
                "a": if (c1 inside {["0":"7"]}) begin hit = 1'b1; val = 5'(c1 - 8'h30) + 5'd10; end
                "x": if (c1 inside {["0":"9"]}) begin hit = 1'b1; val = 5'(c1 - 8'h30); end
                default: ;
            endcase
        end else if (n == 3) begin
            if (c0 == "s" && c1 == "1" && c2 inside {["0":"1"]}) begin
                hit = 1'b1;
                val = 5'(c2 - 8'h30) + 5'd26;
            end else if (c0 == "x" && c1 inside {["1":"3"]} && c2 inside {["0":"9"]}
                         && num <= 8'd31) begin
                // c1 excludes '0', so "x05"/"x00" fall through to the error path.
                hit = 1'b1;
                val = num[4:0];
            end
        end
        dec_err = ovf_q || !hit;
        dec_idx = dec_err ? 5'd0 : val;
    end

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        err_d   = err_q;
        valid_d = valid_q;
        if (flush) begin
            state_d = StIdle;
            tok_d   = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
            idx_d   = 5'd0;
            err_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        if (is_delim) begin
                            if (state_q == StAccum) begin
                                idx_d   = dec_idx;
                                err_d   = dec_err;
                                valid_d = 1'b1;
                                state_d = StEmit;
                            end
                        end else begin
                            if (int'(len_q) < int'(TOK_LEN)) begin
                                for (int i = 0; i < int'(BufLen); i++) begin
                                    if (i == int'(len_q)) tok_d[i] = ch_fold;
                                end
                                len_d = len_q + LenW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                            state_d = StAccum;
                        end
                    end
                end
                StEmit: begin
                    if (reg_ready) begin
                        state_d = StIdle;
                        tok_d   = '0;
                        len_d   = '0;
                        ovf_d   = 1'b0;
                        idx_d   = 5'd0;
                        err_d   = 1'b0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tok_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= 5'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_ascii_reg_parser.sv
// Directed bench for nanorv32_ascii_reg_parser: a string-level token model predicts every
// result, a compare process checks each handshake, and literal checks pin key cases.
module tb_nanorv32_ascii_reg_parser;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [4:0] reg_idx;
    logic       reg_err;
    logic       reg_valid;
    logic       reg_ready;

    int         tests;
    int         fails;
    int         acc_cnt;
    string      cur;
    string      abi_names [32];
    logic [5:0] exp_q [$];
    logic [5:0] exp_e;

    nanorv32_ascii_reg_parser #(.TOK_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .reg_idx    (reg_idx),
        .reg_err    (reg_err),
        .reg_valid  (reg_valid),
        .reg_ready  (reg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // {err, idx} for a complete lowercase token.
    function automatic logic [5:0] model_decode(input string s);
        int  v;
        bit  ok;
        if (s.len() > 4) return {1'b1, 5'd0};
        for (int i = 0; i < 32; i++) if (s == abi_names[i]) return {1'b0, 5'(i)};
        if (s == "fp" || s == "so") return {1'b0, 5'd8};
        if (s.len() >= 2 && s[0] == "x") begin
            v  = 0;
            ok = 1'b1;
            for (int k = 1; k < s.len(); k++) begin
                if (s[k] < "0" || s[k] > "9") ok = 1'b0;
                else v = v * 10 + int'(s[k] - "0");
            end
            if (s.len() > 2 && s[1] == "0") ok = 1'b0;
            if (ok && v <= 31) return {1'b0, 5'(v)};
        end
        return {1'b1, 5'd0};
    endfunction

    function automatic bit is_delim(input logic [7:0] b);
        return b inside {8'h20, 8'h2C, 8'h09, 8'h0D, 8'h0A, 8'h00};
    endfunction

    task automatic model_accept(input logic [7:0] b);
        logic [7:0] f;
        acc_cnt++;
        if (is_delim(b)) begin
            if (cur.len() > 0) exp_q.push_back(model_decode(cur));
            cur = "";
        end else begin
            f   = (b >= "A" && b <= "Z") ? b + 8'h20 : b;
            cur = $sformatf("%s%c", cur, f);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        @(negedge clk);
        char_in    = b;
        char_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (char_ready) begin
                model_accept(b);
                done = 1'b1;
            end
            @(negedge clk);
        end
        char_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL char_accept: byte 0x%02h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && (exp_q.size() != 0 || reg_valid); n++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_char_ready", int'(char_ready), 0);
        cur = "";
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        #1;
    endtask

    // Checks every result at its consumer handshake against the model queue.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && !flush && reg_valid && reg_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got idx %0d err %0d, expected none",
                         reg_idx, reg_err);
            end else begin
                exp_e = exp_q.pop_front();
                check("result_idx", int'(reg_idx), int'(exp_e[4:0]));
                check("result_err", int'(reg_err), int'(exp_e[5]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        abi_names = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                      "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                      "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                      "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
        tests      = 0;
        fails      = 0;
        acc_cnt    = 0;
        cur        = "";
        rst_n      = 1'b0;
        flush      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        reg_ready  = 1'b1;

        // Model pins.
        check("model_s11", int'(model_decode("s11")), 27);
        check("model_x05", int'(model_decode("x05")), 32);

        #1;
        check("reset_valid", int'(reg_valid), 0);
        check("reset_idx", int'(reg_idx), 0);
        check("reset_err", int'(reg_err), 0);
        check("reset_char_ready", int'(char_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single token, latency and EMIT back-pressure on the char side.
        send_str("a0 ");
        #1;
        check("a0_valid", int'(reg_valid), 1);
        check("a0_idx", int'(reg_idx), 10);
        check("a0_err", int'(reg_err), 0);
        check("a0_emit_char_ready", int'(char_ready), 0);
        @(negedge clk);
        #1;
        check("a0_after_valid", int'(reg_valid), 0);
        check("a0_after_char_ready", int'(char_ready), 1);

        send_str("X31,S11\n");
        send_str("fp ");
        send_str("so ");
        drain();

        // Error tokens, including the over-length one.
        acc0 = acc_cnt;
        send_str("zeros ");
        check("zeros_consumed", acc_cnt - acc0, 6);
        send_str("x32 ");
        send_str("x05 ");
        send_str("q ");
        #1;
        check("q_err", int'(reg_err), 1);
        check("q_idx", int'(reg_idx), 0);
        drain();

        // Leading delimiters, then a held result.
        reg_ready = 1'b0;
        send_str("  ,,t6 ");
        char_in    = "r";
        char_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            check("hold_valid", int'(reg_valid), 1);
            check("hold_idx", int'(reg_idx), 31);
            check("hold_err", int'(reg_err), 0);
            check("hold_char_ready", int'(char_ready), 0);
            @(negedge clk);
        end
        reg_ready  = 1'b1;
        char_valid = 1'b0;
        send_str("ra ");
        drain();

        // Flush mid-token, then flush while a result is held.
        send_str("s1");
        do_flush();
        send_str("0 ");
        #1;
        check("flush_tok_err", int'(reg_err), 1);
        drain();
        reg_ready = 1'b0;
        send_str("gp ");
        #1;
        check("emit_before_flush", int'(reg_valid), 1);
        do_flush();
        check("emit_flushed_valid", int'(reg_valid), 0);
        check("emit_flushed_char_ready", int'(char_ready), 1);
        reg_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-token.
        send_str("sp");
        @(negedge clk);
        rst_n = 1'b0;
        cur   = "";
        #1;
        check("rst_valid", int'(reg_valid), 0);
        check("rst_idx", int'(reg_idx), 0);
        check("rst_err", int'(reg_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_str("ra ");
        #1;
        check("ra_after_reset_idx", int'(reg_idx), 1);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
